// File: rtl/error_window_monitor.sv
// Settle-then-observe mismatch qualifier with one valid/ready verdict per window.
// Optional sticky FAIL latch: define ERR_WINDOW_STICKY_EN.
module error_window_monitor #(
  parameter int DATA_WIDTH    = 8,
  parameter int WINDOW_LEN    = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_THRESHOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_Enable,
  input  logic                  i_Error_Flag,
  input  logic                  i_Div_Change,
  input  logic                  i_Ready,
  input  logic                  i_Clear,
  output logic                  o_Valid,
  output logic                  o_Verdict,
  output logic [DATA_WIDTH-1:0] o_Err_Count,
  output logic                  o_Busy,
  output logic                  o_Sticky_Err
);

  localparam int MAXC = (WINDOW_LEN > SETTLE_CYCLES) ?
                        WINDOW_LEN : SETTLE_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW_LEN - 1);
  localparam logic [DATA_WIDTH:0] THR =
    (DATA_WIDTH + 1)'(ERR_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OBSERVE,
    REPORT
  } state_t;

  state_t                state;
  logic [TW-1:0]         tmr;
  logic [DATA_WIDTH-1:0] err_cnt;
  logic [DATA_WIDTH-1:0] err_nxt;
  logic                  go_settle;

  assign err_nxt = (i_Error_Flag && (err_cnt != '1)) ?
                   err_cnt + 1'b1 : err_cnt;

  // Any path back into SETTLE: start, divider change, or accepted verdict.
  assign go_settle = (state == IDLE) |
                     ((state != IDLE) & i_Div_Change) |
                     ((state == REPORT) & i_Ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      err_cnt     <= '0;
      o_Valid     <= 1'b0;
      o_Verdict   <= 1'b0;
      o_Err_Count <= '0;
      o_Busy      <= 1'b0;
    end else if (!i_Enable) begin
      state       <= IDLE;
      tmr         <= '0;
      err_cnt     <= '0;
      o_Valid     <= 1'b0;
      o_Verdict   <= 1'b0;
      o_Err_Count <= '0;
      o_Busy      <= 1'b0;
    end else if (go_settle) begin
      state       <= SETTLE;
      tmr         <= '0;
      err_cnt     <= '0;
      o_Valid     <= 1'b0;
      o_Verdict   <= 1'b0;
      o_Err_Count <= '0;
      o_Busy      <= 1'b1;
    end else begin
      unique case (state)
        SETTLE: begin
          if (tmr == SET_LAST) begin
            state <= OBSERVE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        OBSERVE: begin
          if (tmr == WIN_LAST) begin
            state       <= REPORT;
            tmr         <= '0;
            err_cnt     <= '0;
            o_Valid     <= 1'b1;
            o_Busy      <= 1'b0;
            o_Err_Count <= err_nxt;
            o_Verdict   <= ({1'b0, err_nxt} >= THR);
          end else begin
            err_cnt <= err_nxt;
            tmr     <= tmr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ERR_WINDOW_STICKY_EN
  logic fail_hs;

  assign fail_hs = i_Enable & ~i_Div_Change &
                   (state == REPORT) & i_Ready & o_Verdict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_Sticky_Err <= 1'b0;
    else if (i_Clear)
      o_Sticky_Err <= 1'b0;
    else if (fail_hs)
      o_Sticky_Err <= 1'b1;
  end
`else
  logic unused_clear;

  assign unused_clear = i_Clear;
  assign o_Sticky_Err = 1'b0;
`endif

endmodule

// File: tb/tb_error_window_monitor.sv
// Directed bench for error_window_monitor with a timeline-based reference model.
// Sticky expectations follow ERR_WINDOW_STICKY_EN.
module tb_error_window_monitor;

  localparam int S = 4;
  localparam int W = 16;
  localparam int T = 2;
`ifdef ERR_WINDOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       flag = 1'b0;
  logic       div = 1'b0;
  logic       ready = 1'b0;
  logic       clear = 1'b0;
  logic       valid;
  logic       verdict;
  logic [7:0] count;
  logic       busy;
  logic       sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  error_window_monitor #(
    .DATA_WIDTH(8),
    .WINDOW_LEN(W),
    .SETTLE_CYCLES(S),
    .ERR_THRESHOLD(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_Enable(en),
    .i_Error_Flag(flag),
    .i_Div_Change(div),
    .i_Ready(ready),
    .i_Clear(clear),
    .o_Valid(valid),
    .o_Verdict(verdict),
    .o_Err_Count(count),
    .o_Busy(busy),
    .o_Sticky_Err(sticky)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each window is a timeline anchored at the edge that started it.
  int m_edge, m_start, m_cnt, m_count;
  bit m_on, m_rep, m_verdict, m_sticky;

  task automatic m_restart();
    m_start   = m_edge;
    m_cnt     = 0;
    m_rep     = 1'b0;
    m_verdict = 1'b0;
    m_count   = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0; m_start = 0; m_cnt = 0; m_count = 0;
      m_on = 0; m_rep = 0; m_verdict = 0; m_sticky = 0;
    end else begin
      int e;
      bit hs_fail;
      hs_fail = en && !div && m_rep && ready && m_verdict;
      if (STICKY) begin
        if (clear) m_sticky = 1'b0;
        else if (hs_fail) m_sticky = 1'b1;
      end
      m_edge++;
      if (!en) begin
        m_on = 1'b0;
        m_restart();
      end else if (!m_on) begin
        m_on = 1'b1;
        m_restart();
      end else if (div) begin
        m_restart();
      end else if (m_rep) begin
        if (ready) m_restart();
      end else begin
        e = m_edge - m_start;
        if (e > S && e <= S + W && flag && m_cnt < 255)
          m_cnt++;
        if (e == S + W) begin
          m_rep     = 1'b1;
          m_count   = m_cnt;
          m_verdict = (m_cnt >= T);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", int'(valid), int'(m_rep));
    chk("busy", int'(busy), int'(m_on && !m_rep));
    chk("verdict", int'(verdict), int'(m_verdict));
    chk("count", int'(count), m_count);
    chk("sticky", int'(sticky), int'(m_sticky));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that entered SETTLE; bit i is sampled at edge i+1.
  task automatic run_window(input logic [19:0] pat, input int ec, input int ev);
    for (int i = 0; i < 20; i++) begin
      flag = pat[i];
      tick();
      if (i == 18) chk("early_valid", int'(valid), 0);
    end
    flag = 1'b0;
    chk("win_valid", int'(valid), 1);
    chk("win_count", int'(count), ec);
    chk("win_verdict", int'(verdict), ev);
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("hs_valid", int'(valid), 0);
    chk("hs_busy", int'(busy), 1);
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    en = 1'b1;
    tick();
    n = 0;
    while (!valid && n < 60) begin
      if (busy) n++;
      tick();
    end
    chk("busy_cycles", n, 20);
    chk("first_valid", int'(valid), 1);
    chk("first_count", int'(count), 0);
    chk("first_verdict", int'(verdict), 0);
    accept();

    run_window(20'h00030, 2, 1);
    accept();
    chk("sticky_set", int'(sticky), int'(STICKY));
    run_window(20'h80000, 1, 0);
    accept();
    chk("sticky_hold", int'(sticky), int'(STICKY));
    run_window(20'h0000F, 0, 0);
    clear = 1'b1;
    accept();
    clear = 1'b0;
    chk("sticky_clr", int'(sticky), 0);

    run_window(20'hFFFFF, 16, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", int'(valid), 1);
      chk("hold_count", int'(count), 16);
    end
    accept();
    run_window(20'h00000, 0, 0);
    accept();

    for (int i = 1; i <= 10; i++) begin
      flag = (i >= 5 && i <= 7);
      div = (i == 10);
      tick();
    end
    div = 1'b0;
    flag = 1'b0;
    run_window(20'h10000, 1, 0);
    clear = 1'b1;
    accept();
    clear = 1'b0;

    run_window(20'h000F0, 4, 1);
    div = 1'b1;
    ready = 1'b1;
    tick();
    div = 1'b0;
    ready = 1'b0;
    chk("div_rep_valid", int'(valid), 0);
    chk("div_rep_busy", int'(busy), 1);
    tick();
    chk("div_rep_sticky", int'(sticky), 0);
    en = 1'b0;
    tick();

    en = 1'b1;
    tick();
    run_window(20'h00300, 2, 1);
    en = 1'b0;
    tick();
    chk("dis_valid", int'(valid), 0);
    chk("dis_count", int'(count), 0);
    chk("dis_busy", int'(busy), 0);

    en = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_verdict", int'(verdict), 0);
    flag = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
